// File: rtl/note_judge_if.sv
// Falling-note judge bus: note arrivals and player input towards the judge,
// judgement pulses and HUD values back from it.
interface note_judge_if #(
   parameter int NUM_LANES = 5,
   parameter int SCORE_W   = 16,
   parameter int STREAK_W  = 8
);
   logic                 i_game_start;
   logic                 i_note_valid;
   logic [NUM_LANES-1:0] i_notes;
   logic [NUM_LANES-1:0] i_frets;
   logic                 i_strum;
   logic                 o_hit;
   logic                 o_miss;
   logic                 o_ghost;
   logic [NUM_LANES-1:0] o_pending;
   logic [SCORE_W-1:0]   o_score;
   logic [STREAK_W-1:0]  o_streak;
   logic [2:0]           o_multiplier;

   modport master (
      output i_game_start, i_note_valid, i_notes, i_frets, i_strum,
      input  o_hit, o_miss, o_ghost, o_pending, o_score, o_streak, o_multiplier
   );

   modport slave (
      input  i_game_start, i_note_valid, i_notes, i_frets, i_strum,
      output o_hit, o_miss, o_ghost, o_pending, o_score, o_streak, o_multiplier
   );
endinterface

// File: rtl/note_judge.sv
// Judges notes crossing the strike line against fret/strum input inside a
// timing window, and keeps score, streak and multiplier for the HUD.
module note_judge #(
   parameter int NUM_LANES   = 5,
   parameter int HIT_WINDOW  = 2500000,
   parameter int BASE_POINTS = 10,
   parameter int SCORE_W     = 16,
   parameter int STREAK_W    = 8
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   note_judge_if.slave bus
);
   localparam int TIMER_W = $clog2(HIT_WINDOW);
   localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(HIT_WINDOW - 1);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t               state, state_next;
   logic [NUM_LANES-1:0] pending, pending_next;
   logic [TIMER_W-1:0]   timer, timer_next;
   logic [SCORE_W-1:0]   score, score_next;
   logic [STREAK_W-1:0]  streak, streak_next;
   logic [2:0]           multiplier, multiplier_next;
   logic                 hit, hit_next;
   logic                 miss, miss_next;
   logic                 ghost, ghost_next;
   logic                 new_note;
   logic                 judged;
   logic [SCORE_W:0]     points;
   logic [SCORE_W:0]     score_sum;

   assign new_note  = bus.i_note_valid & (|bus.i_notes);
   assign points    = (SCORE_W+1)'(BASE_POINTS) * (SCORE_W+1)'(multiplier);
   assign score_sum = {1'b0, score} + points;

   function automatic logic [2:0] mult_for(input logic [STREAK_W-1:0] s);
      if (32'(s) >= 30)      return 3'd4;
      else if (32'(s) >= 20) return 3'd3;
      else if (32'(s) >= 10) return 3'd2;
      else                   return 3'd1;
   endfunction

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         pending    <= '0;
         timer      <= '0;
         score      <= '0;
         streak     <= '0;
         multiplier <= 3'd1;
         hit        <= 1'b0;
         miss       <= 1'b0;
         ghost      <= 1'b0;
      end else begin
         state      <= state_next;
         pending    <= pending_next;
         timer      <= timer_next;
         score      <= score_next;
         streak     <= streak_next;
         multiplier <= multiplier_next;
         hit        <= hit_next;
         miss       <= miss_next;
         ghost      <= ghost_next;
      end
   end

   // A strum always decides the pending note; otherwise an overrunning note or
   // an expired timer does. Once decided, a note arriving the same cycle is
   // latched immediately so no note is ever dropped.
   always_comb begin
      state_next      = state;
      pending_next    = pending;
      timer_next      = timer;
      score_next      = score;
      streak_next     = streak;
      hit_next        = 1'b0;
      miss_next       = 1'b0;
      ghost_next      = 1'b0;
      judged          = 1'b0;

      case (state)
         ST_IDLE: begin
            if (new_note) begin
               pending_next = bus.i_notes;
               timer_next   = TIMER_RELOAD;
               state_next   = ST_WAIT;
            end else if (bus.i_strum) begin
               ghost_next = 1'b1;
            end
         end
         ST_WAIT: begin
            if (bus.i_strum) begin
               judged = 1'b1;
               if (bus.i_frets == pending) hit_next  = 1'b1;
               else                        miss_next = 1'b1;
            end else if (new_note || timer == '0) begin
               judged    = 1'b1;
               miss_next = 1'b1;
            end else begin
               timer_next = timer - TIMER_W'(1);
            end
            if (judged) begin
               if (new_note) begin
                  pending_next = bus.i_notes;
                  timer_next   = TIMER_RELOAD;
               end else begin
                  pending_next = '0;
                  timer_next   = '0;
                  state_next   = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (hit_next) begin
         score_next  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
         streak_next = (&streak) ? streak : streak + STREAK_W'(1);
      end else if (miss_next || ghost_next) begin
         streak_next = '0;
      end

      // Game start outranks everything else, including a same-cycle judgement.
      if (bus.i_game_start) begin
         state_next   = ST_IDLE;
         pending_next = '0;
         timer_next   = '0;
         score_next   = '0;
         streak_next  = '0;
         hit_next     = 1'b0;
         miss_next    = 1'b0;
         ghost_next   = 1'b0;
      end

      multiplier_next = mult_for(streak_next);
   end

   assign bus.o_hit        = hit;
   assign bus.o_miss       = miss;
   assign bus.o_ghost      = ghost;
   assign bus.o_pending    = pending;
   assign bus.o_score      = score;
   assign bus.o_streak     = streak;
   assign bus.o_multiplier = multiplier;
endmodule

// File: tb/tb_note_judge.sv
// Directed self-checking bench for note_judge with a short hit window so that
// timeout edges can be checked cycle-exactly.
module tb_note_judge;
   localparam int HIT_WINDOW = 8;

   logic clock;
   logic resetn;
   int   compareCount;
   int   mismatchCount;

   note_judge_if #(.NUM_LANES(5), .SCORE_W(16), .STREAK_W(8)) bus ();

   note_judge #(
      .NUM_LANES(5), .HIT_WINDOW(HIT_WINDOW), .BASE_POINTS(10),
      .SCORE_W(16), .STREAK_W(8)
   ) dut (
      .CLOCK_50(clock),
      .resetn(resetn),
      .bus(bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, let the next rising edge take them, then sample.
   task automatic applyStimulus(input logic gameStart, input logic noteValid, input logic [4:0] notes,
                                input logic [4:0] frets, input logic strum);
      bus.i_game_start = gameStart;
      bus.i_note_valid = noteValid;
      bus.i_notes      = notes;
      bus.i_frets      = frets;
      bus.i_strum      = strum;
      @(posedge clock);
      #1;
      bus.i_game_start = 1'b0;
      bus.i_note_valid = 1'b0;
      bus.i_notes      = '0;
      bus.i_frets      = '0;
      bus.i_strum      = 1'b0;
   endtask

   task automatic playHit(input logic [4:0] lane);
      applyStimulus(0, 1, lane, 5'b0, 0);
      applyStimulus(0, 0, 5'b0, lane, 1);
      applyStimulus(0, 0, 5'b0, 5'b0, 0);
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      bus.i_game_start = 1'b0;
      bus.i_note_valid = 1'b0;
      bus.i_notes      = '0;
      bus.i_frets      = '0;
      bus.i_strum      = 1'b0;
      resetn = 1'b1;
      #2 resetn = 1'b0;
      #2;
      checkOutput("rst_hit", 32'(bus.o_hit), 0);
      checkOutput("rst_pending", 32'(bus.o_pending), 0);
      checkOutput("rst_score", 32'(bus.o_score), 0);
      checkOutput("rst_mult", 32'(bus.o_multiplier), 1);
      #8 resetn = 1'b1;
      @(posedge clock);
      #1;

      // Single hit three cycles after the note lands.
      applyStimulus(0, 1, 5'b00100, 5'b0, 0);
      checkOutput("latch_pending", 32'(bus.o_pending), 32'b00100);
      applyStimulus(0, 0, 5'b0, 5'b0, 0);
      applyStimulus(0, 0, 5'b0, 5'b0, 0);
      applyStimulus(0, 0, 5'b0, 5'b00100, 1);
      checkOutput("hit1_pulse", 32'(bus.o_hit), 1);
      checkOutput("hit1_score", 32'(bus.o_score), 10);
      checkOutput("hit1_streak", 32'(bus.o_streak), 1);
      checkOutput("hit1_pending", 32'(bus.o_pending), 0);
      applyStimulus(0, 0, 5'b0, 5'b0, 0);
      checkOutput("hit1_pulse_end", 32'(bus.o_hit), 0);
      checkOutput("hit1_mult", 32'(bus.o_multiplier), 1);

      // Extra fret held on a chord is a miss.
      applyStimulus(0, 1, 5'b00011, 5'b0, 0);
      applyStimulus(0, 0, 5'b0, 5'b00111, 1);
      checkOutput("chord_miss", 32'(bus.o_miss), 1);
      checkOutput("chord_hit", 32'(bus.o_hit), 0);
      checkOutput("chord_streak", 32'(bus.o_streak), 0);
      checkOutput("chord_score", 32'(bus.o_score), 10);

      // Timeout: still pending after edge N+7, missed at edge N+8.
      applyStimulus(0, 1, 5'b00001, 5'b0, 0);
      for (int i = 0; i < HIT_WINDOW - 1; i++) applyStimulus(0, 0, 5'b0, 5'b0, 0);
      checkOutput("tmo_not_yet", 32'(bus.o_miss), 0);
      checkOutput("tmo_pending", 32'(bus.o_pending), 32'b00001);
      applyStimulus(0, 0, 5'b0, 5'b0, 0);
      checkOutput("tmo_miss", 32'(bus.o_miss), 1);
      checkOutput("tmo_cleared", 32'(bus.o_pending), 0);

      // Strum exactly at edge N+HIT_WINDOW still hits.
      applyStimulus(0, 1, 5'b00010, 5'b0, 0);
      for (int i = 0; i < HIT_WINDOW - 1; i++) applyStimulus(0, 0, 5'b0, 5'b0, 0);
      applyStimulus(0, 0, 5'b0, 5'b00010, 1);
      checkOutput("late_hit", 32'(bus.o_hit), 1);
      checkOutput("late_score", 32'(bus.o_score), 20);

      // Game start clears the score on the next edge.
      applyStimulus(1, 0, 5'b0, 5'b0, 0);
      checkOutput("start_score", 32'(bus.o_score), 0);
      checkOutput("start_streak", 32'(bus.o_streak), 0);

      // Twenty hits in a row walk the multiplier up.
      for (int i = 1; i <= 20; i++) begin
         playHit(5'b01000);
         if (i == 10) begin
            checkOutput("run10_mult", 32'(bus.o_multiplier), 2);
            checkOutput("run10_score", 32'(bus.o_score), 100);
         end
      end
      checkOutput("run20_mult", 32'(bus.o_multiplier), 3);
      checkOutput("run20_score", 32'(bus.o_score), 300);
      checkOutput("run20_streak", 32'(bus.o_streak), 20);

      // Ghost strum with a streak of five.
      applyStimulus(1, 0, 5'b0, 5'b0, 0);
      for (int i = 0; i < 5; i++) playHit(5'b10000);
      checkOutput("pre_ghost_streak", 32'(bus.o_streak), 5);
      applyStimulus(0, 0, 5'b0, 5'b0, 1);
      checkOutput("ghost_pulse", 32'(bus.o_ghost), 1);
      checkOutput("ghost_streak", 32'(bus.o_streak), 0);
      checkOutput("ghost_score", 32'(bus.o_score), 50);

      // Second note during WAIT overruns the first.
      applyStimulus(0, 1, 5'b00001, 5'b0, 0);
      applyStimulus(0, 1, 5'b10000, 5'b0, 0);
      checkOutput("overrun_miss", 32'(bus.o_miss), 1);
      checkOutput("overrun_pending", 32'(bus.o_pending), 32'b10000);
      applyStimulus(0, 0, 5'b0, 5'b10000, 1);
      checkOutput("overrun_hit", 32'(bus.o_hit), 1);
      checkOutput("overrun_score", 32'(bus.o_score), 60);
      applyStimulus(0, 0, 5'b0, 5'b0, 0);

      // Strum with a note arriving in IDLE: note latched, no ghost.
      applyStimulus(0, 1, 5'b00100, 5'b0, 1);
      checkOutput("both_ghost", 32'(bus.o_ghost), 0);
      checkOutput("both_pending", 32'(bus.o_pending), 32'b00100);
      checkOutput("both_streak", 32'(bus.o_streak), 1);
      applyStimulus(0, 0, 5'b0, 5'b0, 0);

      // Asynchronous reset mid-WAIT drops the note silently.
      #2 resetn = 1'b0;
      #1;
      checkOutput("async_pending", 32'(bus.o_pending), 0);
      checkOutput("async_score", 32'(bus.o_score), 0);
      checkOutput("async_mult", 32'(bus.o_multiplier), 1);
      #2 resetn = 1'b1;
      applyStimulus(0, 0, 5'b0, 5'b0, 0);
      checkOutput("async_no_miss", 32'(bus.o_miss), 0);
      checkOutput("async_idle", 32'(bus.o_pending), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end
endmodule
